tetris_matrix_scan: RTL and testbench

- Downstream display stage for the 6x6 Tetris core: consumes the six composited row vectors and game_over and drives a multiplexed 6x6 LED matrix.
- The matrix is driven one row at a time: one-hot row select and column data.
- Features:
  - frame-buffer snapshot at frame boundaries (no tearing)
  - anti-ghost blanking
  - per-row PWM brightness
  - blinking of the game-over pattern

---
 rtl/tetris_matrix_scan.sv | 121 ++++++++++++
 tb/tb_tetris_matrix_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tetris_matrix_scan.sv
// Multiplexed 6x6 LED matrix driver: snapshots the game rows once per frame,
// scans them out row by row with blanking, PWM brightness and game-over blink.
module tetris_matrix_scan #(
    parameter int DWELL        = 8,
    parameter int BLANK        = 1,
    parameter int BLINK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] row0,
    input  logic [5:0] row1,
    input  logic [5:0] row2,
    input  logic [5:0] row3,
    input  logic [5:0] row4,
    input  logic [5:0] row5,
    input  logic       game_over,
    input  logic [2:0] bright,
    output logic [5:0] row_sel,
    output logic [5:0] col_data,
    output logic       frame_start
);

    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DCW-1:0] DC_LAST = DCW'(DWELL - 1);
    localparam logic [FCW-1:0] FC_LAST = FCW'(BLINK_FRAMES - 1);

    logic [DCW-1:0] r_dc;
    logic [2:0]     r_r;
    logic [5:0]     r_fb0, r_fb1, r_fb2, r_fb3, r_fb4, r_fb5;
    logic           r_goQ;
    logic [2:0]     r_brightQ;
    logic [FCW-1:0] r_fcnt;
    logic           r_blink;
    logic           r_frameStart;

    logic           w_rowLast;
    logic           w_eof;
    logic [31:0]    w_dcExt;
    logic           w_active;
    logic           w_inBright;
    logic [5:0]     w_fbRow;

    assign w_rowLast = (r_dc == DC_LAST);
    assign w_eof     = w_rowLast && (r_r == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dc <= '0;
            r_r  <= 3'd0;
        end else if (w_rowLast) begin
            r_dc <= '0;
            r_r  <= (r_r == 3'd5) ? 3'd0 : r_r + 3'd1;
        end else begin
            r_dc <= r_dc + DCW'(1);
        end
    end

    // Everything the display depends on is captured only at frame end, so a
    // frame never mixes two game states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb0        <= 6'd0;
            r_fb1        <= 6'd0;
            r_fb2        <= 6'd0;
            r_fb3        <= 6'd0;
            r_fb4        <= 6'd0;
            r_fb5        <= 6'd0;
            r_goQ        <= 1'b0;
            r_brightQ    <= 3'd0;
            r_fcnt       <= '0;
            r_blink      <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_frameStart <= w_eof;
            if (w_eof) begin
                r_fb0     <= row0;
                r_fb1     <= row1;
                r_fb2     <= row2;
                r_fb3     <= row3;
                r_fb4     <= row4;
                r_fb5     <= row5;
                r_goQ     <= game_over;
                r_brightQ <= bright;
                if (!game_over) begin
                    r_fcnt  <= '0;
                    r_blink <= 1'b0;
                end else if (r_fcnt == FC_LAST) begin
                    r_fcnt  <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_fcnt  <= r_fcnt + FCW'(1);
                end
            end
        end
    end

    always_comb begin
        w_fbRow = 6'd0;
        case (r_r)
            3'd0:    w_fbRow = r_fb0;
            3'd1:    w_fbRow = r_fb1;
            3'd2:    w_fbRow = r_fb2;
            3'd3:    w_fbRow = r_fb3;
            3'd4:    w_fbRow = r_fb4;
            3'd5:    w_fbRow = r_fb5;
            default: w_fbRow = 6'd0;
        endcase
    end

    // The brightness subtraction is only meaningful once past the blanking
    // window, which w_active guarantees before it is used.
    assign w_dcExt    = 32'(r_dc);
    assign w_active   = (w_dcExt >= 32'(BLANK));
    assign w_inBright = ((w_dcExt - 32'(BLANK)) <= 32'(r_brightQ));

    assign row_sel     = w_active ? (6'd1 << r_r) : 6'd0;
    assign col_data    = (w_active && w_inBright && !(r_goQ && r_blink)) ? w_fbRow : 6'd0;
    assign frame_start = r_frameStart;

endmodule

// File: tb/tb_tetris_matrix_scan.sv
// Directed bench for tetris_matrix_scan (DWELL=8, BLANK=1, BLINK_FRAMES=4):
// table-driven brightness/pattern frames plus hand-written multi-frame sequences.
module tb_tetris_matrix_scan;

    logic       clk;
    logic       rst_n;
    logic [5:0] row0, row1, row2, row3, row4, row5;
    logic       game_over;
    logic [2:0] bright;
    logic [5:0] row_sel;
    logic [5:0] col_data;
    logic       frame_start;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct packed {
        logic [5:0][5:0] rows;
        logic [2:0]      bright;
        logic [7:0]      litMask;
    } vector_t;

    vector_t vectors [5];

    tetris_matrix_scan #(.DWELL(8), .BLANK(1), .BLINK_FRAMES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .row0        (row0),
        .row1        (row1),
        .row2        (row2),
        .row3        (row3),
        .row4        (row4),
        .row5        (row5),
        .game_over   (game_over),
        .bright      (bright),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [5:0][5:0] rows, input logic [2:0] br, input logic go);
        row0      = rows[0];
        row1      = rows[1];
        row2      = rows[2];
        row3      = rows[3];
        row4      = rows[4];
        row5      = rows[5];
        bright    = br;
        game_over = go;
    endtask

    task automatic checkOutput(input string name, input logic [5:0] actual, input logic [5:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [5:0] expRowSel(input int k);
        int dc = k % 8;
        int r  = k / 8;
        return (dc >= 1) ? 6'(1 << r) : 6'd0;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Starts at cycle 0 of a frame; ends at cycle 0 of the following frame.
    task automatic checkFrame(input string tag, input logic [5:0][5:0] expRows,
                              input logic [7:0] litMask, input logic blank,
                              input int pokeCycle, input logic [5:0] pokeVal);
        for (int k = 0; k < 48; k++) begin
            int dc = k % 8;
            int r  = k / 8;
            logic [5:0] expCol;
            expCol = (litMask[dc] && !blank) ? expRows[r] : 6'd0;
            checkOutput($sformatf("%s k%0d row_sel", tag, k), row_sel, expRowSel(k));
            checkOutput($sformatf("%s k%0d col_data", tag, k), col_data, expCol);
            checkOutput($sformatf("%s k%0d frame_start", tag, k), {5'd0, frame_start},
                        (k == 0) ? 6'd1 : 6'd0);
            if (k == pokeCycle) row2 = pokeVal;
            nextCycle();
        end
    endtask

    task automatic advanceFrame(input string tag);
        repeat (48) nextCycle();
        checkOutput($sformatf("%s advance frame_start", tag), {5'd0, frame_start}, 6'd1);
    endtask

    // Current time is just after reset release (state dc=0, r=0); ends at cycle 48.
    task automatic checkFirstFrame(input string tag);
        for (int k = 0; k < 48; k++) begin
            if (k > 0) nextCycle();
            checkOutput($sformatf("%s k%0d row_sel", tag, k), row_sel, expRowSel(k));
            checkOutput($sformatf("%s k%0d col_data", tag, k), col_data, 6'd0);
            checkOutput($sformatf("%s k%0d frame_start", tag, k), {5'd0, frame_start}, 6'd0);
        end
        nextCycle();
    endtask

    logic [5:0][5:0] allFull, all15, row2Low, row2High, goPattern;

    initial begin
        allFull   = {6{6'h3F}};
        all15     = {6{6'h15}};
        row2Low   = {6'h15, 6'h15, 6'h15, 6'h00, 6'h15, 6'h15};
        row2High  = {6'h15, 6'h15, 6'h15, 6'h21, 6'h15, 6'h15};
        goPattern = {6'h21, 6'h12, 6'h0C, 6'h0C, 6'h12, 6'h21};

        vectors[0] = '{rows: allFull, bright: 3'd7, litMask: 8'hFE};
        vectors[1] = '{rows: all15, bright: 3'd2, litMask: 8'h0E};
        vectors[2] = '{rows: {6'h20, 6'h10, 6'h08, 6'h04, 6'h02, 6'h01}, bright: 3'd0, litMask: 8'h02};
        vectors[3] = '{rows: goPattern, bright: 3'd4, litMask: 8'h3E};
        vectors[4] = '{rows: {6'h2A, 6'h15, 6'h2A, 6'h15, 6'h2A, 6'h15}, bright: 3'd5, litMask: 8'h7E};

        // Reset state and the blank first frame after release
        rst_n = 1'b0;
        applyStimulus(allFull, 3'd7, 1'b0);
        repeat (3) nextCycle();
        checkOutput("reset row_sel", row_sel, 6'd0);
        checkOutput("reset col_data", col_data, 6'd0);
        checkOutput("reset frame_start", {5'd0, frame_start}, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkFirstFrame("first");
        checkFrame("after-first", allFull, 8'hFE, 1'b0, -1, 6'd0);

        // Brightness and pattern table
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vectors[i].rows, vectors[i].bright, 1'b0);
            advanceFrame($sformatf("vec%0d", i));
            checkFrame($sformatf("vec%0d", i), vectors[i].rows, vectors[i].litMask, 1'b0, -1, 6'd0);
        end

        // Mid-frame row change only shows up in the following frame
        applyStimulus(row2Low, 3'd2, 1'b0);
        advanceFrame("tear");
        checkFrame("tear N", row2Low, 8'h0E, 1'b0, 10, 6'h21);
        checkFrame("tear N+1", row2High, 8'h0E, 1'b0, -1, 6'd0);

        // Game-over blink, drop mid-blink, then re-raise
        applyStimulus(goPattern, 3'd7, 1'b1);
        advanceFrame("go");
        for (int j = 0; j < 15; j++) begin
            if (j == 4) game_over = 1'b0;
            if (j == 6) game_over = 1'b1;
            checkFrame($sformatf("go j%0d", j), goPattern, 8'hFE,
                       (j == 3) || (j == 4) || (j >= 10 && j <= 13), -1, 6'd0);
        end

        // Asynchronous reset in the middle of a lit row
        applyStimulus(allFull, 3'd7, 1'b0);
        advanceFrame("arst");
        repeat (29) nextCycle();
        checkOutput("pre-arst row_sel", row_sel, 6'h08);
        checkOutput("pre-arst col_data", col_data, 6'h3F);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst row_sel", row_sel, 6'd0);
        checkOutput("arst col_data", col_data, 6'd0);
        checkOutput("arst frame_start", {5'd0, frame_start}, 6'd0);
        repeat (2) nextCycle();
        @(negedge clk);
        rst_n = 1'b1;
        checkFirstFrame("post-arst");
        checkFrame("post-arst lit", allFull, 8'hFE, 1'b0, -1, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
